otter_mem_arbiter: RTL and testbench

//  Shares one single-ported OTTER memory between the instruction-fetch port (IF) and the

---
 rtl/otter_arb_pkg.sv | 22 ++
 rtl/otter_arb_timer.sv | 35 +++
 rtl/otter_mem_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_otter_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_arb_pkg.sv
// Shared types for the OTTER IF/DM memory arbiter.
package otter_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } mem_size_e;

endpackage

// File: rtl/otter_arb_timer.sv
// Transaction watchdog: counts enabled cycles, flags the TIMEOUT-th one.
module otter_arb_timer #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc_c
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_c = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/otter_mem_arbiter.sv
// Shares one single-ported memory between instruction fetch (IF) and load/store (DM);
// one transaction in flight, response routed back to its owner.
module otter_mem_arbiter
    import otter_arb_pkg::*;
#(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          IF_REQ,
    input  logic [AW-1:0] IF_ADDR,
    output logic          IF_ACK,
    output logic [DW-1:0] IF_RDATA,
    input  logic          DM_REQ,
    input  logic          DM_WE,
    input  logic [AW-1:0] DM_ADDR,
    input  logic [DW-1:0] DM_WDATA,
    input  logic [1:0]    DM_SIZE,
    input  logic          DM_SIGN,
    output logic          DM_ACK,
    output logic [DW-1:0] DM_RDATA,
    output logic          ERR,
    output logic          MEM_REQ,
    input  logic          MEM_READY,
    output logic          MEM_WE,
    output logic [AW-1:0] MEM_ADDR,
    output logic [DW-1:0] MEM_WDATA,
    output logic [1:0]    MEM_SIZE,
    output logic          MEM_SIGN,
    input  logic          MEM_VALID,
    input  logic [DW-1:0] MEM_RDATA
);

    localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]    mem_size_q, mem_size_d;
    logic          mem_sign_q, mem_sign_d;
    logic          if_ack_q, if_ack_d;
    logic          dm_ack_q, dm_ack_d;
    logic          err_q, err_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic [SW-1:0] starve_q, starve_d;

    logic          tmr_clr, tmr_en, tmr_tc_c;
    logic          grant_fire, grant_if;
    logic          xfer_done, xfer_err;
    logic [DW-1:0] xfer_data;

    otter_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk   (CLK),
        .rst_n (RST_N),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .tc_c  (tmr_tc_c)
    );

    // The ACK cycle is spent in IDLE without granting, so a REQ still high there is not re-served.
    assign grant_fire = (state_q == IDLE) && !(if_ack_q || dm_ack_q) && (IF_REQ || DM_REQ);
    assign grant_if   = IF_REQ && (!DM_REQ || (starve_q == SW'(STARVE_MAX)));

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_size_d  = mem_size_q;
        mem_sign_d  = mem_sign_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        err_d       = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        starve_d    = starve_q;
        tmr_clr     = 1'b0;
        tmr_en      = 1'b0;
        xfer_done   = 1'b0;
        xfer_err    = 1'b0;
        xfer_data   = '0;

        case (state_q)
            IDLE: begin
                tmr_clr = 1'b1;
                if (grant_fire) begin
                    state_d   = ISSUE;
                    mem_req_d = 1'b1;
                    if (grant_if) begin
                        owner_d     = OWN_IF;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = IF_ADDR;
                        mem_wdata_d = '0;
                        mem_size_d  = SZ_WORD;
                        mem_sign_d  = 1'b0;
                    end else begin
                        owner_d     = OWN_DM;
                        mem_we_d    = DM_WE;
                        mem_addr_d  = DM_ADDR;
                        mem_wdata_d = DM_WDATA;
                        mem_size_d  = DM_SIZE;
                        mem_sign_d  = DM_SIGN;
                    end
                end
            end
            ISSUE: begin
                if (MEM_READY) begin
                    state_d   = WAIT;
                    mem_req_d = 1'b0;
                    tmr_clr   = 1'b1;
                end else if (tmr_tc_c) begin
                    xfer_done = 1'b1;
                    xfer_err  = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            WAIT: begin
                if (MEM_VALID) begin
                    xfer_done = 1'b1;
                    xfer_data = MEM_RDATA;
                end else if (tmr_tc_c) begin
                    xfer_done = 1'b1;
                    xfer_err  = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Completion (normal or aborted) acks the owner; aborted data reads as zero.
        if (xfer_done) begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
            err_d     = xfer_err;
            if (owner_q == OWN_DM) begin
                dm_ack_d   = 1'b1;
                dm_rdata_d = xfer_data;
            end else begin
                if_ack_d   = 1'b1;
                if_rdata_d = xfer_data;
            end
        end

        if (!IF_REQ || (grant_fire && grant_if)) begin
            starve_d = '0;
        end else if (grant_fire && (starve_q != SW'(STARVE_MAX))) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_size_q  <= '0;
            mem_sign_q  <= 1'b0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            err_q       <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            starve_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_size_q  <= mem_size_d;
            mem_sign_q  <= mem_sign_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            err_q       <= err_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            starve_q    <= starve_d;
        end
    end

    assign IF_ACK    = if_ack_q;
    assign IF_RDATA  = if_rdata_q;
    assign DM_ACK    = dm_ack_q;
    assign DM_RDATA  = dm_rdata_q;
    assign ERR       = err_q;
    assign MEM_REQ   = mem_req_q;
    assign MEM_WE    = mem_we_q;
    assign MEM_ADDR  = mem_addr_q;
    assign MEM_WDATA = mem_wdata_q;
    assign MEM_SIZE  = mem_size_q;
    assign MEM_SIGN  = mem_sign_q;

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Scoreboard bench for otter_mem_arbiter: expected requests/acks queued by stimulus, popped by monitors.
module tb_otter_mem_arbiter;

    localparam int TIMEOUT = 64;

    logic        CLK, RST_N;
    logic        IF_REQ, IF_ACK;
    logic [31:0] IF_ADDR, IF_RDATA;
    logic        DM_REQ, DM_WE, DM_SIGN, DM_ACK;
    logic [31:0] DM_ADDR, DM_WDATA, DM_RDATA;
    logic [1:0]  DM_SIZE;
    logic        ERR, MEM_REQ, MEM_READY, MEM_WE, MEM_SIGN, MEM_VALID;
    logic [31:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;
    logic [1:0]  MEM_SIZE;

    bit          ready_en, valid_en, stray_valid;
    logic        mv_model;
    logic [31:0] mv_data;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    typedef struct { bit is_dm; logic [31:0] rdata; bit err; } ack_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [1:0] size; logic sign; } req_t;
    ack_t ack_q[$];
    req_t req_q[$];

    otter_mem_arbiter dut (
        .CLK(CLK), .RST_N(RST_N),
        .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_ACK(IF_ACK), .IF_RDATA(IF_RDATA),
        .DM_REQ(DM_REQ), .DM_WE(DM_WE), .DM_ADDR(DM_ADDR), .DM_WDATA(DM_WDATA),
        .DM_SIZE(DM_SIZE), .DM_SIGN(DM_SIGN), .DM_ACK(DM_ACK), .DM_RDATA(DM_RDATA),
        .ERR(ERR), .MEM_REQ(MEM_REQ), .MEM_READY(MEM_READY), .MEM_WE(MEM_WE),
        .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN),
        .MEM_VALID(MEM_VALID), .MEM_RDATA(MEM_RDATA)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [31:0] data_for(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h0000_0013;
            32'h0000_0104: return 32'h0050_0093;
            32'h0000_0200: return 32'h0000_00AB;
            32'h0000_0300: return 32'h00A0_0113;
            32'h0000_0400: return 32'h1122_3344;
            default:       return 32'hBAD0_BAD0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic exp_ack(input bit dm, input logic [31:0] d, input bit e);
        ack_t t;
        t.is_dm = dm; t.rdata = d; t.err = e;
        ack_q.push_back(t);
    endtask

    task automatic exp_req(input logic we, input logic [31:0] a, input logic [31:0] w,
                           input logic [1:0] s, input logic sg);
        req_t t;
        t.we = we; t.addr = a; t.wdata = w; t.size = s; t.sign = sg;
        req_q.push_back(t);
    endtask

    task automatic wait_ack(input bit dm, input int budget, output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge CLK); #2;
            if ((dm ? DM_ACK : IF_ACK) === 1'b1) begin
                at_cyc = cyc;
                break;
            end
        end
        if (at_cyc < 0) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout port_dm=%0d actual=none required=ack within %0d cycles", dm, budget);
        end
    endtask

    task automatic set_dm(input logic we, input logic [31:0] a, input logic [31:0] w,
                          input logic [1:0] s, input logic sg);
        DM_WE = we; DM_ADDR = a; DM_WDATA = w; DM_SIZE = s; DM_SIGN = sg;
    endtask

    // Memory model: combinational READY, VALID one cycle after acceptance.
    assign MEM_READY = (MEM_REQ === 1'b1) && ready_en;
    assign MEM_VALID = mv_model | stray_valid;
    assign MEM_RDATA = stray_valid ? 32'hFFFF_FFFF : mv_data;

    initial begin
        bit          acc;
        logic [31:0] a;
        logic        w;
        mv_model = 1'b0;
        mv_data  = '0;
        forever begin
            @(negedge CLK);
            acc = (MEM_REQ === 1'b1) && (MEM_READY === 1'b1) && valid_en;
            a   = MEM_ADDR;
            w   = MEM_WE;
            @(posedge CLK); #1;
            mv_model = acc;
            mv_data  = acc ? (w ? 32'h0 : data_for(a)) : 32'h0;
        end
    end

    // Request monitor: every accepted memory request is compared with the expected order.
    initial begin
        req_t e;
        forever begin
            @(negedge CLK);
            if (MEM_REQ === 1'b1 && MEM_READY === 1'b1) begin
                if (req_q.size() == 0) begin
                    check("unexpected_mem_req", MEM_ADDR, 32'hFFFF_FFFF);
                end else begin
                    e = req_q.pop_front();
                    check("mem_we",    {31'b0, MEM_WE},   {31'b0, e.we});
                    check("mem_addr",  MEM_ADDR,          e.addr);
                    check("mem_wdata", MEM_WDATA,         e.wdata);
                    check("mem_size",  {30'b0, MEM_SIZE}, {30'b0, e.size});
                    check("mem_sign",  {31'b0, MEM_SIGN}, {31'b0, e.sign});
                end
            end
        end
    end

    // Response monitor: every ACK pops one expected response.
    initial begin
        ack_t e;
        forever begin
            @(posedge CLK); #1;
            if (IF_ACK === 1'b1 && DM_ACK === 1'b1) check("dual_ack", 32'd1, 32'd0);
            if (IF_ACK === 1'b1 || DM_ACK === 1'b1) begin
                if (ack_q.size() == 0) begin
                    check("unexpected_ack", {30'b0, DM_ACK, IF_ACK}, 32'd0);
                end else begin
                    e = ack_q.pop_front();
                    check("ack_port_dm", {31'b0, DM_ACK}, {31'b0, e.is_dm});
                    check("ack_rdata", e.is_dm ? DM_RDATA : IF_RDATA, e.rdata);
                    check("ack_err", {31'b0, ERR}, {31'b0, e.err});
                end
            end else if (ERR === 1'b1) begin
                check("err_without_ack", 32'd1, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, at, at2;
        RST_N = 1'b0; IF_REQ = 1'b1; DM_REQ = 1'b1; IF_ADDR = 32'h100;
        set_dm(1'b1, 32'h6000, 32'hDEAD_BEEF, 2'b10, 1'b0);
        ready_en = 1'b1; valid_en = 1'b1; stray_valid = 1'b0;

        // 1: reset with both requests high
        repeat (2) @(posedge CLK);
        #2;
        check("rst_if_ack",   {31'b0, IF_ACK},  32'd0);
        check("rst_dm_ack",   {31'b0, DM_ACK},  32'd0);
        check("rst_err",      {31'b0, ERR},     32'd0);
        check("rst_mem_req",  {31'b0, MEM_REQ}, 32'd0);
        check("rst_mem_we",   {31'b0, MEM_WE},  32'd0);
        check("rst_mem_addr", MEM_ADDR,         32'd0);
        check("rst_mem_wdata", MEM_WDATA,       32'd0);
        check("rst_mem_size", {30'b0, MEM_SIZE}, 32'd0);
        check("rst_if_rdata", IF_RDATA,         32'd0);
        check("rst_dm_rdata", DM_RDATA,         32'd0);
        IF_REQ = 1'b0; DM_REQ = 1'b0;
        @(posedge CLK); #2;
        RST_N = 1'b1;
        @(posedge CLK); #2;

        // 2: IF only, zero-wait memory
        exp_req(1'b0, 32'h100, 32'h0, 2'b10, 1'b0);
        exp_ack(1'b0, 32'h0000_0013, 1'b0);
        IF_ADDR = 32'h100; IF_REQ = 1'b1; c0 = cyc;
        @(posedge CLK); #2;
        check("if_mem_req_cycle1", {31'b0, MEM_REQ}, 32'd1);
        wait_ack(1'b0, 10, at);
        IF_REQ = 1'b0;
        check("if_ack_latency", 32'(at - c0), 32'd3);
        @(posedge CLK); #2;

        // 3: simultaneous store and fetch; DM first, IF back-to-back
        exp_req(1'b1, 32'h6000, 32'hDEAD_BEEF, 2'b10, 1'b0);
        exp_req(1'b0, 32'h104, 32'h0, 2'b10, 1'b0);
        exp_ack(1'b1, 32'h0, 1'b0);
        exp_ack(1'b0, 32'h0050_0093, 1'b0);
        set_dm(1'b1, 32'h6000, 32'hDEAD_BEEF, 2'b10, 1'b0);
        IF_ADDR = 32'h104; DM_REQ = 1'b1; IF_REQ = 1'b1; c0 = cyc;
        wait_ack(1'b1, 10, at);
        DM_REQ = 1'b0;
        check("dm_store_ack_latency", 32'(at - c0), 32'd3);
        @(posedge CLK); #2;
        check("no_grant_in_ack_cycle", {31'b0, MEM_REQ}, 32'd0);
        @(posedge CLK); #2;
        check("if_grant_after_ack", {31'b0, MEM_REQ}, 32'd1);
        wait_ack(1'b0, 10, at2);
        IF_REQ = 1'b0;
        check("if_ack_after_dm", 32'(at2 - at), 32'd4);
        @(posedge CLK); #2;

        // 4: starvation - four DM grants, then IF, then DM again (counter cleared)
        for (int i = 0; i < 4; i++) begin
            exp_req(1'b0, 32'h200, 32'h5555_0000, 2'b00, 1'b1);
            exp_ack(1'b1, 32'h0000_00AB, 1'b0);
        end
        exp_req(1'b0, 32'h300, 32'h0, 2'b10, 1'b0);
        exp_ack(1'b0, 32'h00A0_0113, 1'b0);
        exp_req(1'b0, 32'h200, 32'h5555_0000, 2'b00, 1'b1);
        exp_ack(1'b1, 32'h0000_00AB, 1'b0);
        set_dm(1'b0, 32'h200, 32'h5555_0000, 2'b00, 1'b1);
        IF_ADDR = 32'h300; DM_REQ = 1'b1; IF_REQ = 1'b1;
        for (int i = 0; i < 4; i++) wait_ack(1'b1, 10, at);
        wait_ack(1'b0, 10, at);
        wait_ack(1'b1, 10, at);
        DM_REQ = 1'b0; IF_REQ = 1'b0;
        repeat (2) @(posedge CLK);
        #2;

        // 5: WAIT timeout, then a stray MEM_VALID
        valid_en = 1'b0;
        exp_req(1'b0, 32'h400, 32'h0, 2'b10, 1'b0);
        exp_ack(1'b1, 32'h0, 1'b1);
        set_dm(1'b0, 32'h400, 32'h0, 2'b10, 1'b0);
        DM_REQ = 1'b1; c0 = cyc;
        wait_ack(1'b1, TIMEOUT + 20, at);
        DM_REQ = 1'b0;
        check("wait_timeout_latency", 32'(at - c0), 32'(2 + TIMEOUT));
        @(posedge CLK); #2;
        stray_valid = 1'b1;
        @(posedge CLK); #2;
        stray_valid = 1'b0;
        repeat (3) begin
            @(posedge CLK); #2;
            check("stray_valid_no_ack", {30'b0, DM_ACK, IF_ACK}, 32'd0);
        end

        // 5b: MEM_READY never rises, ISSUE times out
        ready_en = 1'b0;
        exp_ack(1'b0, 32'h0, 1'b1);
        IF_ADDR = 32'h104; IF_REQ = 1'b1; c0 = cyc;
        wait_ack(1'b0, TIMEOUT + 20, at);
        IF_REQ = 1'b0;
        check("issue_timeout_latency", 32'(at - c0), 32'(1 + TIMEOUT));
        @(posedge CLK); #2;
        check("issue_timeout_req_drop", {31'b0, MEM_REQ}, 32'd0);
        ready_en = 1'b1;

        // 6: reset during WAIT abandons the transaction
        exp_req(1'b0, 32'h200, 32'h0, 2'b01, 1'b0);
        set_dm(1'b0, 32'h200, 32'h0, 2'b01, 1'b0);
        DM_REQ = 1'b1;
        repeat (2) @(posedge CLK);
        #2;
        RST_N = 1'b0; DM_REQ = 1'b0;
        @(posedge CLK); #2;
        RST_N = 1'b1;
        check("midrst_mem_req",  {31'b0, MEM_REQ}, 32'd0);
        check("midrst_mem_addr", MEM_ADDR,         32'd0);
        stray_valid = 1'b1;
        @(posedge CLK); #2;
        stray_valid = 1'b0;
        valid_en = 1'b1;
        repeat (3) begin
            @(posedge CLK); #2;
            check("midrst_no_ack", {30'b0, DM_ACK, IF_ACK}, 32'd0);
        end
        exp_req(1'b0, 32'h100, 32'h0, 2'b10, 1'b0);
        exp_ack(1'b0, 32'h0000_0013, 1'b0);
        IF_ADDR = 32'h100; IF_REQ = 1'b1; c0 = cyc;
        wait_ack(1'b0, 10, at);
        IF_REQ = 1'b0;
        check("post_reset_if_latency", 32'(at - c0), 32'd3);
        repeat (3) @(posedge CLK);
        #2;

        check("ack_queue_drained", 32'(ack_q.size()), 32'd0);
        check("req_queue_drained", 32'(req_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
